// File: rtl/encoder_poll_scheduler_if.sv
// Purpose: bundles the scheduler's control, response and status signals for the encoder poll path.
// Latency: wiring only, no logic.
// Backpressure: none. Requests and responses are single-cycle pulses. Status outputs are registered in the scheduler.
//
// Ports (slave = scheduler view):
//   inputs : enable, host_req, resp_valid, resp_angle[23:0], resp_crc_ok
//   outputs: key, busy, angle_out[23:0], angle_valid, host_done, xfer_fail,
//            timeout_cnt[15:0], crc_err_cnt[15:0]
interface encoder_poll_scheduler_if;
  logic        enable;
  logic        host_req;
  logic        resp_valid;
  logic [23:0] resp_angle;
  logic        resp_crc_ok;
  logic        key;
  logic        busy;
  logic [23:0] angle_out;
  logic        angle_valid;
  logic        host_done;
  logic        xfer_fail;
  logic [15:0] timeout_cnt;
  logic [15:0] crc_err_cnt;

  // Motion-control side plus response source: drives requests and responses, observes status.
  modport master (
    output enable, host_req, resp_valid, resp_angle, resp_crc_ok,
    input  key, busy, angle_out, angle_valid, host_done, xfer_fail,
    timeout_cnt, crc_err_cnt
  );

  // Scheduler side.
  modport slave (
    input  enable, host_req, resp_valid, resp_angle, resp_crc_ok,
    output key, busy, angle_out, angle_valid, host_done, xfer_fail,
    timeout_cnt, crc_err_cnt
  );
endinterface

// File: rtl/encoder_poll_scheduler.sv
// Purpose: issues encoder acquire triggers from a poll timer and host requests, with timeout, CRC retry and angle latch.
// Latency: host_req to key takes 2 cycles. A good resp_valid gives angle_valid 1 cycle later. host_done follows angle_valid by GAP_CYC cycles.
// Backpressure: none. Requests that arrive while busy are held as one pending flag per source and merge; they are never queued.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : encoder_poll_scheduler_if.slave. It carries the enable, host_req and resp_* inputs,
//                and the key, busy, angle_*, host_done, xfer_fail, timeout_cnt and crc_err_cnt outputs.
module encoder_poll_scheduler #(
  parameter int PERIOD_CYC  = 10000,
  parameter int TRIG_CYC    = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int GAP_CYC     = 200,
  parameter int MAX_RETRY   = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  encoder_poll_scheduler_if.slave  bus
);

  localparam int TMR_W   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  // One phase counter serves the TRIG, WAIT and GAP states. Size it for the longest of the three.
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC)
                           ? ((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC)
                           : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               retry_pend_q, retry_pend_d;
  logic               pend_poll_q, pend_poll_d;
  logic               pend_host_q, pend_host_d;
  // Only the host origin needs tracking. A poll-only transaction has no completion pulse.
  logic               cur_host_q, cur_host_d;
  logic               key_q, key_d;
  logic               busy_q, busy_d;
  logic [23:0]        angle_q, angle_d;
  logic               angle_valid_q, angle_valid_d;
  logic               host_done_q, host_done_d;
  logic               xfer_fail_q, xfer_fail_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic [15:0]        crc_cnt_q, crc_cnt_d;

  logic               poll_tick;
  logic               take;
  logic               err;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    retry_pend_d  = retry_pend_q;
    cur_host_d    = cur_host_q;
    angle_d       = angle_q;
    angle_valid_d = 1'b0;
    host_done_d   = 1'b0;
    xfer_fail_d   = 1'b0;
    to_cnt_d      = to_cnt_q;
    crc_cnt_d     = crc_cnt_q;
    take          = 1'b0;
    err           = 1'b0;

    // Free-running poll timer. Its terminal count is the poll tick.
    poll_tick = bus.enable && (timer_q == TMR_W'(PERIOD_CYC - 1));
    if (!bus.enable) begin
      timer_d = '0;
    end else if (poll_tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (pend_poll_q || pend_host_q) begin
          take       = 1'b1;
          cur_host_d = pend_host_q;
          retry_d    = '0;
          cnt_d      = '0;
          state_d    = TRIG;
        end
      end

      TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT: begin
        // A response takes precedence over a timeout that lands in the same cycle.
        if (bus.resp_valid) begin
          if (bus.resp_crc_ok) begin
            angle_d       = bus.resp_angle;
            angle_valid_d = 1'b1;
            retry_pend_d  = 1'b0;
            cnt_d         = '0;
            state_d       = GAP;
          end else begin
            crc_cnt_d = (crc_cnt_q == 16'hFFFF) ? crc_cnt_q : crc_cnt_q + 16'd1;
            err       = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_cnt_d = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
          err      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        // Every error passes through GAP. retry_pend records whether GAP leads back to TRIG.
        if (err) begin
          cnt_d   = '0;
          state_d = GAP;
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d      = retry_q + RTY_W'(1);
            retry_pend_d = 1'b1;
          end else begin
            xfer_fail_d  = 1'b1;
            retry_pend_d = 1'b0;
          end
        end
      end

      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (retry_pend_q) begin
            state_d = TRIG;
          end else begin
            state_d     = IDLE;
            host_done_d = cur_host_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A request that arrives in the same cycle as a take re-arms its flag, so it is not lost.
    // A poll tick that arrives while pend_poll is already set leaves the flag at 1, so the overrun is dropped.
    pend_poll_d = bus.enable && (poll_tick || (pend_poll_q && !take));
    pend_host_d = bus.host_req || (pend_host_q && !take);

    // key and busy are registered from the next state, so both change on the same edge as the state.
    key_d  = (state_d == TRIG);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      cnt_q         <= '0;
      retry_q       <= '0;
      retry_pend_q  <= 1'b0;
      pend_poll_q   <= 1'b0;
      pend_host_q   <= 1'b0;
      cur_host_q    <= 1'b0;
      key_q         <= 1'b0;
      busy_q        <= 1'b0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      host_done_q   <= 1'b0;
      xfer_fail_q   <= 1'b0;
      to_cnt_q      <= '0;
      crc_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      retry_pend_q  <= retry_pend_d;
      pend_poll_q   <= pend_poll_d;
      pend_host_q   <= pend_host_d;
      cur_host_q    <= cur_host_d;
      key_q         <= key_d;
      busy_q        <= busy_d;
      angle_q       <= angle_d;
      angle_valid_q <= angle_valid_d;
      host_done_q   <= host_done_d;
      xfer_fail_q   <= xfer_fail_d;
      to_cnt_q      <= to_cnt_d;
      crc_cnt_q     <= crc_cnt_d;
    end
  end

  assign bus.key         = key_q;
  assign bus.busy        = busy_q;
  assign bus.angle_out   = angle_q;
  assign bus.angle_valid = angle_valid_q;
  assign bus.host_done   = host_done_q;
  assign bus.xfer_fail   = xfer_fail_q;
  assign bus.timeout_cnt = to_cnt_q;
  assign bus.crc_err_cnt = crc_cnt_q;

endmodule
